// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM widths, timing defaults and sequencer state encoding
package sram_pkg;

    localparam int SRAM_AW     = 21;
    localparam int SRAM_DW     = 8;
    localparam int CNT_W       = 4;

    localparam int T_SETUP_DEF = 1;
    localparam int T_PULSE_DEF = 3;
    localparam int T_HOLD_DEF  = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sram_access_seq_if.sv
// rtl/sram_access_seq_if.sv - core-side request/ack bus of the SRAM access sequencer
interface sram_access_seq_if;
    import sram_pkg::*;

    logic               req;
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
    logic               busy;
    logic               ack;
    logic [SRAM_DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  busy, ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, ack, rdata
    );

endinterface

// File: rtl/sram_access_seq.sv
// rtl/sram_access_seq.sv - turns single-cycle requests into timed async-SRAM strobe sequences
module sram_access_seq
    import sram_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    sram_access_seq_if.slave   bus,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_nce,
    output logic               sram_noe,
    output logic               sram_nwe
);

    // The timing counter is 4 bits wide; anything it cannot express is rejected at elaboration.
    if (T_SETUP < 0 || T_SETUP > 15) begin : g_bad_setup
        $error("T_SETUP out of range 0..15");
    end
    if (T_PULSE < 1 || T_PULSE > 15) begin : g_bad_pulse
        $error("T_PULSE out of range 1..15");
    end
    if (T_HOLD < 0 || T_HOLD > 15) begin : g_bad_hold
        $error("T_HOLD out of range 0..15");
    end

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               we_q, we_nx;
    logic               accept;
    logic               active_nx;

    // Next-state and counter: each timed state loads (width-1) on entry and exits when it hits zero.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        we_nx    = we_q;
        accept   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    we_nx  = bus.we;
                    if (T_SETUP > 0) begin
                        state_nx = ST_SETUP;
                        cnt_nx   = SETUP_LD;
                    end else begin
                        state_nx = ST_PULSE;
                        cnt_nx   = PULSE_LD;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nx = ST_PULSE;
                    cnt_nx   = PULSE_LD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    if (T_HOLD > 0) begin
                        state_nx = ST_HOLD;
                        cnt_nx   = HOLD_LD;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Chip is selected in every timed state; the DONE cycle deselects it.
    always_comb begin
        active_nx = (state_nx == ST_SETUP) || (state_nx == ST_PULSE) || (state_nx == ST_HOLD);
    end

    // State plus all outputs registered from the next-state decode so strobes are glitch-free.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            sram_a     <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_nce   <= 1'b1;
            sram_noe   <= 1'b1;
            sram_nwe   <= 1'b1;
            bus.busy   <= 1'b0;
            bus.ack    <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            we_q       <= we_nx;
            if (accept) begin
                sram_a <= bus.addr;
                if (bus.we) begin
                    sram_dq_o <= bus.wdata;
                end
            end
            sram_nce   <= !active_nx;
            sram_noe   <= !((state_nx == ST_PULSE) && !we_nx);
            sram_nwe   <= !((state_nx == ST_PULSE) && we_nx);
            sram_dq_oe <= active_nx && we_nx;
            bus.busy   <= (state_nx != ST_IDLE);
            bus.ack    <= (state_nx == ST_DONE);
            // Sample read data on the edge that ends the last pulse cycle, while nOE is still low.
            if ((state == ST_PULSE) && (cnt == '0) && !we_q) begin
                bus.rdata <= sram_dq_i;
            end
        end
    end

endmodule

// File: doc/sram_access_seq.md
Name: sram_access_seq

Overview:
Bus-to-SRAM access sequencer that sits directly upstream of the SRAM-to-SDRAM-pin wrapper on the SRAM add-on board. It turns single-cycle read/write requests from the core into correctly timed asynchronous-SRAM strobe sequences: 21-bit address, 8-bit data, nCE/nOE/nWE. Setup, pulse and hold widths are set by parameters. Read data is captured and returned with a one-cycle ack.

Parameters:
T_SETUP, 1, cycles with address/CE valid before the strobe; legal 0..15.
T_PULSE, 3, cycles nOE/nWE held low; legal 1..15.
T_HOLD, 1, cycles CE/address/write data held after the strobe rises; legal 0..15.

Ports:
clk_sys  in  1  system clock; all logic on the rising edge.
reset_n  in  1  reset, asynchronous assert, active-low.
req  in  1  single-cycle request strobe; accepted only when busy=0.
we  in  1  1=write, 0=read; sampled with req.
addr  in  21  byte address; sampled with req.
wdata  in  8  write data; sampled with req.
busy  out  1  high from the cycle after acceptance through the ack cycle.
ack  out  1  one-cycle completion pulse.
rdata  out  8  read data; valid in the ack cycle of a read, held until the next read completes.
sram_a  out  21  SRAM address to the wrapper.
sram_dq_o  out  8  SRAM write data.
sram_dq_oe  out  1  top-level tristate enable for SRAM_DQ.
sram_dq_i  in  8  SRAM read data from the tristate.
sram_nce  out  1  chip enable, active-low.
sram_noe  out  1  output enable, active-low.
sram_nwe  out  1  write enable, active-low.

Behaviour:
- Clock and reset: one clock, clk_sys; reset_n is asynchronous and active-low. All outputs are registered, so strobes are glitch-free.
- Reset values: sram_nce=sram_noe=sram_nwe=1, sram_dq_oe=0, sram_a=0, sram_dq_o=0, ack=0, busy=0, rdata=0, state=IDLE.
- FSM states: IDLE, SETUP, PULSE, HOLD, DONE. A 4-bit down-counter times each state.
- IDLE:
  - req=1 at edge E0 latches addr/we/wdata.
  - Next state is SETUP, or PULSE if T_SETUP=0.
  - nCE goes low and sram_a is driven from the cycle after E0.
  - For a write, sram_dq_o=wdata and dq_oe=1 from that same cycle.
- SETUP: T_SETUP cycles; nOE=nWE=1.
- PULSE: T_PULSE cycles; nOE=0 for a read, nWE=0 for a write.
- Read capture: rdata captures sram_dq_i at the edge ending the last PULSE cycle, while nOE is still low.
- HOLD: T_HOLD cycles; strobes high; nCE, address and write data/dq_oe unchanged. Skipped if T_HOLD=0.
- DONE: one cycle; ack=1, busy=1, nCE=1, dq_oe=0. Next state is always IDLE.
- Latency: ack occurs in cycle T_SETUP+T_PULSE+T_HOLD+1 after E0 (defaults: cycle 6). Minimum issue interval is that value +1.
- Read transactions: dq_oe=0 for the whole transaction.
- Write transactions: rdata is unchanged.
- Address hold: sram_a holds the last address in IDLE and is not cleared.
- req while busy=1, including the DONE cycle, is ignored and not queued. The requester must retry once busy=0.
- req and reset together: reset wins.
- reset_n low mid-transaction:
  - Strobes go high and dq_oe low immediately.
  - No ack is issued.
  - A write in progress may be corrupted; this is accepted.
- Counter width: 4 bits; parameter values outside the legal range are a synthesis-time error.

Decomposition:
- Shared package sram_pkg holds:
  - state encodings;
  - SRAM_AW=21 and SRAM_DW=8;
  - default timing constants, shared with the wrapper top.
- No sub-module: the FSM plus counter fits in one module. The DQ tristate stays at top level next to the wrapper.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles, then release -> nce/noe/nwe=1, dq_oe=0, ack=0, busy=0, rdata=0x00 throughout.
2. Write with defaults: req, we=1, addr=0x1ABCD, wdata=0xA5 at E0 -> sram_a=0x1ABCD and nce=0 in cycles 1-5, nwe=0 in cycles 2-4, dq_oe=1 with dq_o=0xA5 in cycles 1-5, ack in cycle 6, noe=1 throughout.
3. Read with defaults: SRAM model returns 0x3C at 0x00042 -> noe=0 in cycles 2-4, dq_oe=0, ack and rdata=0x3C in cycle 6. A following write leaves rdata=0x3C.
4. Busy drop: second req in cycles 3 and 6 -> both ignored, exactly one ack. req in cycle 7 (IDLE) -> accepted.
5. Minimum timing (T_SETUP=0, T_PULSE=1, T_HOLD=0): read -> noe=0 in cycle 1 only, ack in cycle 2.
6. Reset mid-operation: assert reset_n=0 during cycle 3 of a write -> nwe/nce=1 and dq_oe=0 without waiting for a clock edge, no ack. After release, a new read completes normally.
